note_sequencer: RTL and testbench

Melody sequencer that drives the stereo tone divisors of the audio speaker/I2S path from a small programmable score memory instead of live buttons. It sits between the frequency divider (beat tick), the debounced control buttons (play/pause/stop) and the speaker block, and outputs `note_div_left`/`note_div_right` plus a mute flag. The score is written through a simple write port while idle. The score is then stepped entry by entry on beat ticks, with optional looping.

---
 rtl/note_sequencer.sv | 165 ++++++++++++++++
 tb/tb_note_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Score-memory melody sequencer: steps a small programmable score on beat ticks and
// drives registered stereo tone divisors plus a mute flag for the speaker path.
module note_sequencer #(
    parameter int CLK_HZ = 100_000_000,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat_tick,
    input  logic          play,
    input  logic          pause,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [5:0]    length,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [10:0]   wr_data,
    output logic [21:0]   note_div_left,
    output logic [21:0]   note_div_right,
    output logic          mute,
    output logic          playing,
    output logic [AW-1:0] idx,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, PAUSE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx_n;
    logic [3:0]    code_l, code_r, code_l_n, code_r_n;
    logic [2:0]    cnt, cnt_n;
    logic [21:0]   div_l_n, div_r_n;
    logic          mute_n, playing_n, done_n;
    logic [10:0]   entry;
    logic          len_ok, last;

    logic [10:0] ram [DEPTH];

    function automatic logic [21:0] note_div(input logic [3:0] code);
        case (code)
            4'd1:    return 22'(CLK_HZ / 262);
            4'd2:    return 22'(CLK_HZ / 294);
            4'd3:    return 22'(CLK_HZ / 330);
            4'd4:    return 22'(CLK_HZ / 349);
            4'd5:    return 22'(CLK_HZ / 392);
            4'd6:    return 22'(CLK_HZ / 440);
            4'd7:    return 22'(CLK_HZ / 494);
            4'd8:    return 22'(CLK_HZ / 523);
            4'd9:    return 22'(CLK_HZ / 587);
            4'd10:   return 22'(CLK_HZ / 659);
            4'd11:   return 22'(CLK_HZ / 698);
            4'd12:   return 22'(CLK_HZ / 784);
            4'd13:   return 22'(CLK_HZ / 880);
            4'd14:   return 22'(CLK_HZ / 988);
            4'd15:   return 22'(CLK_HZ / 1047);
            default: return 22'd0;
        endcase
    endfunction

    // NOTE: the score RAM has no reset so it maps onto memory and survives rst.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE)
            ram[wr_addr] <= wr_data;
    end

    assign entry  = ram[idx];
    assign len_ok = (length != 6'd0) && (length <= 6'(DEPTH));
    assign last   = (6'(idx) + 6'd1) >= length;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        code_l_n = code_l;
        code_r_n = code_r;
        cnt_n    = cnt;
        done_n   = 1'b0;
        if (stop) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: if (play && len_ok) begin
                    state_n = LOAD;
                    idx_n   = '0;
                end
                LOAD: begin
                    // Latch even when pausing here, so a later resume plays this entry.
                    code_l_n = entry[10:7];
                    code_r_n = entry[6:3];
                    cnt_n    = entry[2:0];
                    state_n  = pause ? PAUSE : PLAY;
                end
                PLAY: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (beat_tick) begin
                        if (cnt != 3'd0) begin
                            cnt_n = cnt - 3'd1;
                        end else if (!last) begin
                            idx_n   = idx + 1'b1;
                            state_n = LOAD;
                        end else if (loop_en) begin
                            idx_n   = '0;
                            state_n = LOAD;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                PAUSE: if (play) state_n = PLAY;
                default: state_n = IDLE;
            endcase
        end

        // Outputs are derived from the next state so they stay fully registered.
        div_l_n   = note_div_left;
        div_r_n   = note_div_right;
        mute_n    = mute;
        playing_n = (state_n == LOAD) || (state_n == PLAY);
        case (state_n)
            PLAY: begin
                div_l_n = note_div(code_l_n);
                div_r_n = note_div(code_r_n);
                mute_n  = (code_l_n == 4'd0) && (code_r_n == 4'd0);
            end
            LOAD: ;
            default: begin
                div_l_n = '0;
                div_r_n = '0;
                mute_n  = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            code_l         <= '0;
            code_r         <= '0;
            cnt            <= '0;
            note_div_left  <= '0;
            note_div_right <= '0;
            mute           <= 1'b1;
            playing        <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            code_l         <= code_l_n;
            code_r         <= code_r_n;
            cnt            <= cnt_n;
            note_div_left  <= div_l_n;
            note_div_right <= div_r_n;
            mute           <= mute_n;
            playing        <= playing_n;
            done           <= done_n;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus pushes the expected post-edge outputs,
// a monitor pops and compares them after every clock edge.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst, beat_tick, play, pause, stop, loop_en, wr_en;
    logic [5:0]  length;
    logic [4:0]  wr_addr;
    logic [10:0] wr_data;
    logic [21:0] note_div_left, note_div_right;
    logic        mute, playing, done;
    logic [4:0]  idx;

    typedef struct packed {
        logic [21:0] dl;
        logic [21:0] dr;
        logic        mute;
        logic        playing;
        logic [4:0]  idx;
        logic        done;
    } exp_t;

    localparam logic [21:0] D1  = 22'd381679;
    localparam logic [21:0] D6  = 22'd227272;
    localparam logic [21:0] D8  = 22'd191204;
    localparam logic [21:0] D13 = 22'd113636;
    localparam logic [21:0] D15 = 22'd95510;

    exp_t  sb[$];
    string tags[$];
    string tag;
    exp_t  want, got;
    string cur;
    int    compared = 0;
    int    mismatched = 0;

    note_sequencer dut (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .play(play), .pause(pause),
        .stop(stop), .loop_en(loop_en), .length(length), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .note_div_left(note_div_left),
        .note_div_right(note_div_right), .mute(mute), .playing(playing),
        .idx(idx), .done(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t e(input logic [21:0] l, input logic [21:0] r, input logic m,
                               input logic p, input logic [4:0] i, input logic d);
        exp_t x;
        x = '{dl: l, dr: r, mute: m, playing: p, idx: i, done: d};
        return x;
    endfunction

    exp_t idle0;
    exp_t start0;

    // Push the outputs expected after the coming edge, then clear one-cycle pulses.
    task automatic cyc(input exp_t x);
        sb.push_back(x);
        tags.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        beat_tick = 0; play = 0; pause = 0; stop = 0; wr_en = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] l, input logic [3:0] r,
                      input logic [2:0] d);
        wr_en = 1; wr_addr = a; wr_data = {l, r, d};
        cyc(idle0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            want = sb.pop_front();
            cur  = tags.pop_front();
            got  = '{dl: note_div_left, dr: note_div_right, mute: mute, playing: playing,
                     idx: idx, done: done};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL %s: got dl=%0d dr=%0d mute=%0b playing=%0b idx=%0d done=%0b, want dl=%0d dr=%0d mute=%0b playing=%0b idx=%0d done=%0b",
                         cur, got.dl, got.dr, got.mute, got.playing, got.idx, got.done,
                         want.dl, want.dr, want.mute, want.playing, want.idx, want.done);
            end
        end
    end

    initial begin
        idle0  = e(0, 0, 1, 0, 0, 0);
        start0 = e(0, 0, 1, 1, 0, 0);
        rst = 1; beat_tick = 0; play = 0; pause = 0; stop = 0; loop_en = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; length = 6'd3;
        @(negedge clk);
        tag = "reset";
        cyc(idle0);
        cyc(idle0);
        rst = 0;

        tag = "program";
        wr(5'd0, 4'd1, 4'd8, 3'd0);
        wr(5'd1, 4'd6, 4'd13, 3'd1);
        wr(5'd2, 4'd0, 4'd0, 3'd0);

        tag = "oneshot";
        play = 1;      cyc(start0);
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 2, 0));
        beat_tick = 1; cyc(e(0, 0, 1, 1, 2, 0));
        beat_tick = 1; cyc(e(0, 0, 1, 0, 2, 1));
        beat_tick = 1; cyc(e(0, 0, 1, 0, 2, 0));

        tag = "loop";
        loop_en = 1;
        play = 1;      cyc(start0);
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 2, 0));
        beat_tick = 1; cyc(e(0, 0, 1, 1, 2, 0));
        beat_tick = 1; cyc(e(0, 0, 1, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 0, 0));
        stop = 1;      cyc(idle0);
        loop_en = 0;

        tag = "pause_resume";
        play = 1;      cyc(start0);
        cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        cyc(e(D6, D13, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 1, 0));
        pause = 1;     cyc(e(0, 0, 1, 0, 1, 0));
        for (int i = 0; i < 5; i++) begin
            beat_tick = 1; cyc(e(0, 0, 1, 0, 1, 0));
        end
        play = 1;      cyc(e(D6, D13, 0, 1, 1, 0));
        cyc(e(D6, D13, 0, 1, 1, 0));
        beat_tick = 1; cyc(e(D6, D13, 0, 1, 2, 0));
        stop = 1;      cyc(idle0);

        tag = "same_cycle";
        play = 1;      cyc(start0);
        cyc(e(D1, D8, 0, 1, 0, 0));
        pause = 1; beat_tick = 1; cyc(e(0, 0, 1, 0, 0, 0));
        play = 1;      cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        cyc(e(D6, D13, 0, 1, 1, 0));
        stop = 1; play = 1; cyc(idle0);
        cyc(idle0);

        tag = "write_in_play";
        play = 1;      cyc(start0);
        cyc(e(D1, D8, 0, 1, 0, 0));
        wr_en = 1; wr_addr = 5'd1; wr_data = {4'd15, 4'd0, 3'd0};
        cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        cyc(e(D6, D13, 0, 1, 1, 0));
        stop = 1;      cyc(idle0);

        tag = "bad_length";
        length = 6'd0;  play = 1; cyc(idle0);
        cyc(idle0);
        length = 6'd33; play = 1; cyc(idle0);
        length = 6'd3;

        tag = "reset_mid";
        play = 1;      cyc(start0);
        cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        cyc(e(D6, D13, 0, 1, 1, 0));
        rst = 1;       cyc(idle0);
        rst = 0;
        play = 1;      cyc(start0);
        cyc(e(D1, D8, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D1, D8, 0, 1, 1, 0));
        cyc(e(D6, D13, 0, 1, 1, 0));
        stop = 1;      cyc(idle0);

        tag = "len1_c6";
        wr(5'd0, 4'd15, 4'd15, 3'd2);
        length = 6'd1;
        play = 1;      cyc(start0);
        cyc(e(D15, D15, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D15, D15, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(D15, D15, 0, 1, 0, 0));
        beat_tick = 1; cyc(e(0, 0, 1, 0, 0, 1));
        cyc(idle0);

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
